// File: rtl/dt_ctrl.sv
// ---------------------------------------------------------------------------
// dt_ctrl -- dT source controller
//
// Sequences an external dT estimator (init pulse, warm-up, run) and selects
// between an externally supplied dT and the estimator output. Estimator
// configuration (alpha, k_dt, d_max) is written into a pending set at any
// time and only becomes active together with an init pulse, so the
// estimator never sees its coefficients change mid-run.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              run request (level); low forces IDLE
//   dt_mode             0 = external dT_ext, 1 = estimator est_dT
//   dT_ext              external dT, signed Q7.0
//   cfg_wr              single-cycle strobe capturing cfg_alpha/cfg_k/cfg_dmax
//   est_dT, est_valid   estimator output and its valid
//   est_init            one-cycle init pulse to the estimator
//   est_alpha/k/dmax    active configuration driven to the estimator
//   dT_out, dT_valid    selected dT (registered, one-cycle latency)
//   state               FSM state: 0 IDLE, 1 INIT, 2 WARMUP, 3 RUN
//   reinit_cnt          init pulses issued, saturating at 255
// ---------------------------------------------------------------------------
module dt_ctrl #(
    parameter int unsigned WARMUP_N  = 16,
    parameter logic [7:0]  ALPHA_RST = 8'd32,
    parameter logic [7:0]  K_RST     = 8'd0,
    parameter logic [7:0]  DMAX_RST  = 8'd127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       dt_mode,
    input  logic [7:0] dT_ext,
    input  logic       cfg_wr,
    input  logic [7:0] cfg_alpha,
    input  logic [7:0] cfg_k,
    input  logic [7:0] cfg_dmax,
    input  logic [7:0] est_dT,
    input  logic       est_valid,
    output logic       est_init,
    output logic [7:0] est_alpha,
    output logic [7:0] est_k,
    output logic [7:0] est_dmax,
    output logic [7:0] dT_out,
    output logic       dT_valid,
    output logic [1:0] state,
    output logic [7:0] reinit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INIT   = 2'd1,
        S_WARMUP = 2'd2,
        S_RUN    = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic       init_q, init_d;
    logic       pend_q, pend_d;
    logic [7:0] p_alpha_q, p_alpha_d;
    logic [7:0] p_k_q, p_k_d;
    logic [7:0] p_dmax_q, p_dmax_d;
    logic [7:0] alpha_q, alpha_d;
    logic [7:0] k_q, k_d;
    logic [7:0] dmax_q, dmax_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       mode_q, mode_d;
    logic [7:0] dt_q, dt_d;
    logic       dtv_q, dtv_d;
    logic [7:0] rcnt_q, rcnt_d;

    logic       run_hold;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        p_alpha_d = p_alpha_q;
        p_k_d     = p_k_q;
        p_dmax_d  = p_dmax_q;
        alpha_d   = alpha_q;
        k_d       = k_q;
        dmax_d    = dmax_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        mode_d    = dt_mode;
        run_hold  = 1'b0;
        dt_d      = 8'd0;
        dtv_d     = 1'b0;

        // Capture into the pending set; k_dt is clamped to its legal range.
        if (cfg_wr) begin
            p_alpha_d = cfg_alpha;
            p_k_d     = (cfg_k > 8'd7) ? 8'd7 : cfg_k;
            p_dmax_d  = cfg_dmax;
            pend_d    = 1'b1;
        end

        unique case (state_q)
            S_IDLE: state_d = S_INIT;
            S_INIT: begin
                state_d = dt_mode ? S_WARMUP : S_RUN;
                wcnt_d  = 8'd0;
            end
            S_WARMUP: begin
                if (est_valid) begin
                    if (({1'b0, wcnt_q} + 9'd1) == 9'(WARMUP_N))
                        state_d = S_RUN;
                    else
                        wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_RUN: begin
                // A same-cycle cfg_wr re-inits immediately rather than a cycle
                // later; a 1->0 mode change needs no re-init.
                if (pend_q || cfg_wr || (dt_mode && !mode_q))
                    state_d = S_INIT;
            end
        endcase

        if (!enable)
            state_d = S_IDLE;

        // Config goes live on the edge into INIT so est_* and est_init move
        // together. A write landing during INIT itself stays pending and
        // triggers another init once RUN is reached.
        if (state_d == S_INIT) begin
            alpha_d = p_alpha_d;
            k_d     = p_k_d;
            dmax_d  = p_dmax_d;
            pend_d  = 1'b0;
            if (rcnt_q != 8'hFF)
                rcnt_d = rcnt_q + 8'd1;
        end

        init_d = (state_d == S_INIT);

        // Output only while staying in RUN, so the cycle spent in INIT/IDLE
        // after leaving RUN already shows dT_valid=0.
        run_hold = (state_q == S_RUN) && (state_d == S_RUN);
        if (run_hold) begin
            dt_d  = dt_mode ? est_dT : dT_ext;
            dtv_d = dt_mode ? est_valid : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            init_q    <= 1'b0;
            pend_q    <= 1'b0;
            p_alpha_q <= ALPHA_RST;
            p_k_q     <= K_RST;
            p_dmax_q  <= DMAX_RST;
            alpha_q   <= ALPHA_RST;
            k_q       <= K_RST;
            dmax_q    <= DMAX_RST;
            wcnt_q    <= 8'd0;
            mode_q    <= 1'b0;
            dt_q      <= 8'd0;
            dtv_q     <= 1'b0;
            rcnt_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            pend_q    <= pend_d;
            p_alpha_q <= p_alpha_d;
            p_k_q     <= p_k_d;
            p_dmax_q  <= p_dmax_d;
            alpha_q   <= alpha_d;
            k_q       <= k_d;
            dmax_q    <= dmax_d;
            wcnt_q    <= wcnt_d;
            mode_q    <= mode_d;
            dt_q      <= dt_d;
            dtv_q     <= dtv_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign state      = state_q;
    assign est_init   = init_q;
    assign est_alpha  = alpha_q;
    assign est_k      = k_q;
    assign est_dmax   = dmax_q;
    assign dT_out     = dt_q;
    assign dT_valid   = dtv_q;
    assign reinit_cnt = rcnt_q;

endmodule

// File: tb/tb_dt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dt_ctrl -- scoreboard bench for dt_ctrl.
// The driver applies inputs on the falling edge, advances a behavioural model
// and queues the outputs expected after the next rising edge; the monitor
// pops and compares after every rising edge. Directed scenarios come first,
// followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_dt_ctrl;
    localparam int WN = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       dt_mode = 1'b0;
    logic [7:0] dT_ext = 8'd0;
    logic       cfg_wr = 1'b0;
    logic [7:0] cfg_alpha = 8'd0;
    logic [7:0] cfg_k = 8'd0;
    logic [7:0] cfg_dmax = 8'd0;
    logic [7:0] est_dT = 8'd0;
    logic       est_valid = 1'b0;

    logic       est_init;
    logic [7:0] est_alpha, est_k, est_dmax, dT_out, reinit_cnt;
    logic       dT_valid;
    logic [1:0] state;

    dt_ctrl #(.WARMUP_N(WN), .ALPHA_RST(8'd32), .K_RST(8'd0), .DMAX_RST(8'd127)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dt_mode(dt_mode),
        .dT_ext(dT_ext), .cfg_wr(cfg_wr), .cfg_alpha(cfg_alpha), .cfg_k(cfg_k),
        .cfg_dmax(cfg_dmax), .est_dT(est_dT), .est_valid(est_valid),
        .est_init(est_init), .est_alpha(est_alpha), .est_k(est_k),
        .est_dmax(est_dmax), .dT_out(dT_out), .dT_valid(dT_valid),
        .state(state), .reinit_cnt(reinit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       init;
        logic [7:0] a;
        logic [7:0] k;
        logic [7:0] d;
        logic [7:0] dt;
        logic       v;
        logic [7:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // ---------------- behavioural model ----------------
    // States: 0 idle, 1 init, 2 warmup, 3 run. Warm-up is tracked as the
    // number of valid samples still to be discarded.
    int         m_st = 0, m_left = 0, m_cnt = 0;
    bit         m_pend = 0, m_prev = 0, m_v = 0;
    logic [7:0] m_pa = 8'd32, m_pk = 8'd0, m_pd = 8'd127;
    logic [7:0] m_a = 8'd32, m_k = 8'd0, m_d = 8'd127, m_dt = 8'd0;

    function automatic obs_t snap_dut();
        obs_t o;
        o.st = state; o.init = est_init; o.a = est_alpha; o.k = est_k;
        o.d = est_dmax; o.dt = dT_out; o.v = dT_valid; o.cnt = reinit_cnt;
        return o;
    endfunction

    task automatic model_reset();
        m_st = 0; m_left = 0; m_cnt = 0; m_pend = 0; m_prev = 0; m_v = 0;
        m_pa = 8'd32; m_pk = 8'd0; m_pd = 8'd127;
        m_a = 8'd32; m_k = 8'd0; m_d = 8'd127; m_dt = 8'd0;
    endtask

    task automatic model_step();
        int   nxt;
        bit   was_run;
        obs_t e;
        if (!rst_n) begin
            model_reset();
        end else begin
            was_run = (m_st == 3);
            if (cfg_wr) begin
                m_pa = cfg_alpha;
                m_pk = (cfg_k > 8'd7) ? 8'd7 : cfg_k;
                m_pd = cfg_dmax;
                m_pend = 1;
            end
            case (m_st)
                0: nxt = 1;
                1: begin nxt = dt_mode ? 2 : 3; m_left = WN; end
                2: begin
                    nxt = 2;
                    if (est_valid) begin
                        m_left = m_left - 1;
                        if (m_left == 0) nxt = 3;
                    end
                end
                default: nxt = (m_pend || (dt_mode && !m_prev)) ? 1 : 3;
            endcase
            if (!enable) nxt = 0;
            if (nxt == 1) begin
                m_a = m_pa; m_k = m_pk; m_d = m_pd; m_pend = 0;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
            if (was_run && nxt == 3) begin
                m_dt = dt_mode ? est_dT : dT_ext;
                m_v  = dt_mode ? est_valid : 1'b1;
            end else begin
                m_dt = 8'd0;
                m_v  = 0;
            end
            m_prev = dt_mode;
            m_st   = nxt;
        end
        e.st = 2'(m_st); e.init = (m_st == 1); e.a = m_a; e.k = m_k; e.d = m_d;
        e.dt = m_dt; e.v = m_v; e.cnt = 8'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic compare(input string name, input obs_t act, input obs_t e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s cyc=%0d act st=%0d init=%0b a=%0d k=%0d d=%0d dt=%0d v=%0b cnt=%0d | exp st=%0d init=%0b a=%0d k=%0d d=%0d dt=%0d v=%0b cnt=%0d",
                     name, cyc, act.st, act.init, act.a, act.k, act.d, $signed(act.dt), act.v, act.cnt,
                     e.st, e.init, e.a, e.k, e.d, $signed(e.dt), e.v, e.cnt);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("cycle", snap_dut(), e);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        obs_t rst_exp;
        rst_exp = '{st: 2'd0, init: 1'b0, a: 8'd32, k: 8'd0, d: 8'd127, dt: 8'd0, v: 1'b0, cnt: 8'd0};

        @(negedge clk);
        repeat (3) tick();

        // Startup, internal mode
        rst_n = 1'b1; dt_mode = 1'b1; enable = 1'b1; est_valid = 1'b1; est_dT = 8'd5;
        repeat (22) tick();

        // Config during RUN
        cfg_wr = 1'b1; cfg_alpha = 8'd64; cfg_k = 8'd3; cfg_dmax = 8'd20;
        tick();
        cfg_wr = 1'b0;
        repeat (20) tick();

        // k saturation, last write wins, zero alpha/dmax stored as-is
        cfg_wr = 1'b1; cfg_alpha = 8'd1; cfg_k = 8'd1; cfg_dmax = 8'd1;
        tick();               // RUN -> INIT
        cfg_wr = 1'b0;
        tick();               // INIT -> WARMUP
        cfg_wr = 1'b1; cfg_alpha = 8'd0; cfg_k = 8'd200; cfg_dmax = 8'd0;
        tick();
        cfg_k = 8'd9; cfg_alpha = 8'd0; cfg_dmax = 8'd0;
        tick();
        cfg_wr = 1'b0;
        repeat (40) tick();

        // Mode switching, -128 bit-exact
        dt_mode = 1'b0; dT_ext = 8'h80;
        repeat (3) tick();
        dt_mode = 1'b1;
        repeat (20) tick();
        dt_mode = 1'b0; dT_ext = 8'h7F;
        repeat (3) tick();

        // Abort paths: enable low in WARMUP
        dt_mode = 1'b1;
        repeat (4) tick();
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        repeat (25) tick();

        // Asynchronous reset in RUN
        rst_n = 1'b0;
        #1;
        compare("async_reset", snap_dut(), rst_exp);
        model_reset();
        #3;
        repeat (2) tick();
        rst_n = 1'b1; enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (4) tick();

        // Randomized phase
        repeat (3000) begin
            enable    = ($urandom_range(0, 40) != 0);
            if ($urandom_range(0, 19) == 0) dt_mode = ~dt_mode;
            cfg_wr    = ($urandom_range(0, 24) == 0);
            cfg_alpha = 8'($urandom);
            cfg_k     = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            cfg_dmax  = 8'($urandom);
            est_valid = ($urandom_range(0, 3) != 0);
            est_dT    = 8'($urandom);
            dT_ext    = 8'($urandom);
            tick();
        end

        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain act %0d pending exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dt_ctrl.md
DT_CTRL -- requirements
Module: dt_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- WARMUP_N, 16, estimator samples discarded after each init (1..255)
- ALPHA_RST, 32, reset value of the active alpha
- K_RST, 0, reset value of the active k_dt
- DMAX_RST, 127, reset value of the active d_max

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst_n, in, 1, reset; asynchronous, active-low
- enable, in, 1, run request; level-sensitive
- dt_mode, in, 1, source select: 0 = external dT, 1 = internal estimator
- dT_ext, in, 8, external dT, signed Q7.0
- cfg_wr, in, 1, single-cycle config write strobe
- cfg_alpha, in, 8, alpha write data
- cfg_k, in, 8, k_dt write data
- cfg_dmax, in, 8, d_max write data
- est_dT, in, 8, estimator output, signed Q7.0
- est_valid, in, 1, estimator valid
- est_init, out, 1, one-cycle init pulse to the estimator
- est_alpha, out, 8, active alpha driven to the estimator
- est_k, out, 8, active k_dt driven to the estimator
- est_dmax, out, 8, active d_max driven to the estimator
- dT_out, out, 8, selected dT, signed Q7.0, registered
- dT_valid, out, 1, dT_out valid
- state, out, 2, FSM state code
- reinit_cnt, out, 8, count of init pulses issued; saturates at 255

Function
REQ-003 The FSM SHALL have states IDLE=0, INIT=1, WARMUP=2, RUN=3, encoded on `state`.
REQ-004 IDLE SHALL go to INIT on the first clk with enable=1.
REQ-005 INIT SHALL last exactly one cycle, with est_init=1 only in INIT.
REQ-006 INIT SHALL go to WARMUP when dt_mode=1, and to RUN when dt_mode=0.
REQ-007 In any state, enable=0 SHALL force IDLE on the next clk; this overrides every other transition.
REQ-008 cfg_wr SHALL capture cfg_alpha, cfg_k and cfg_dmax into pending registers and set pend=1 in any state.
- A later cfg_wr before apply overwrites the pending values (last write wins).
REQ-009 Pending values SHALL be copied to est_alpha/est_k/est_dmax only in the INIT cycle, and pend SHALL clear there.
- Consequence: est_* change together with est_init, never mid-run.
REQ-010 cfg_k values above 7 SHALL be saturated to 7 on capture; alpha and dmax SHALL be stored unmodified, 0 included.
REQ-011 In WARMUP, an 8-bit counter SHALL clear on entry and increment on each cycle with est_valid=1.
- WARMUP SHALL go to RUN on the cycle the counter would reach WARMUP_N.
REQ-012 In RUN, pend=1 or a dt_mode 0->1 transition (detected via a registered dt_mode copy) SHALL cause INIT on the next clk.
- A 1->0 transition SHALL keep RUN.
REQ-013 cfg_wr coinciding with the INIT cycle SHALL land in pending with pend=1, and SHALL cause a further INIT after the current init sequence.
REQ-014 dT_out SHALL be registered with one-cycle latency.
- In RUN: dT_out <= (dt_mode ? est_dT : dT_ext).
- dT_valid <= dt_mode ? est_valid : 1.
REQ-015 In IDLE, INIT and WARMUP, dT_valid SHALL be 0 and dT_out SHALL be 0.
REQ-016 reinit_cnt SHALL increment once per INIT cycle and saturate at 255.
REQ-017 The selection path SHALL carry no arithmetic on dT; values pass bit-exact, including -128.

Reset
REQ-018 While rst_n=0, the outputs SHALL be:
- state=IDLE, est_init=0
- est_alpha=ALPHA_RST, est_k=K_RST, est_dmax=DMAX_RST
- dT_out=0, dT_valid=0, reinit_cnt=0
- pend=0, warmup counter 0, registered dt_mode=0
REQ-019 Reset asserted mid-operation SHALL abort any state asynchronously; no est_init pulse SHALL be generated on reset release until enable is seen.

Verification
REQ-020 Startup, internal mode:
- Stimulus: reset; dt_mode=1, enable=1, est_valid=1 constant, est_dT=5.
- Response: est_init high exactly on cycle 1; WARMUP for 16 cycles; first dT_valid=1 with dT_out=5 one cycle after RUN entry.
REQ-021 Config during RUN:
- Stimulus: cfg_wr with alpha=64, k=3, dmax=20.
- Response: next cycle INIT; est_alpha=64, est_k=3, est_dmax=20 in that cycle; dT_valid=0 until WARMUP completes; reinit_cnt increments by 1.
REQ-022 k saturation and last write wins:
- Stimulus: cfg_k=200, then cfg_k=9 on the following cycle, both during WARMUP.
- Response: est_k=7 after the next INIT.
REQ-023 Mode switching:
- Stimulus: dT_ext=-128, dt_mode=0 in RUN.
- Response: dT_out=-128, dT_valid=1.
- Stimulus: switch dt_mode to 1.
- Response: INIT, then WARMUP; switching back to 0 stays in RUN.
REQ-024 Abort paths:
- Stimulus: enable=0 in WARMUP.
- Response: IDLE next cycle, dT_valid=0.
- Stimulus: rst_n pulsed low in RUN.
- Response: all outputs return to reset values immediately; no est_init until enable is seen.
